// File: rtl/data_mem_pkg.sv
// Shared constants for the data memory responder: I/O page location,
// register offsets inside that page, and timer control bit positions.
package data_mem_pkg;

  localparam logic [7:0] IO_PAGE      = 8'hFF;

  localparam logic [7:0] OFS_IO_OUT   = 8'h00;
  localparam logic [7:0] OFS_IO_IN    = 8'h01;
  localparam logic [7:0] OFS_STATUS   = 8'h02;
  localparam logic [7:0] OFS_TIMER    = 8'h03;
  localparam logic [7:0] OFS_TMR_CTRL = 8'h04;
  localparam logic [7:0] OFS_TMR_CMP  = 8'h05;

  localparam int TMR_CTRL_EN_BIT  = 0;
  localparam int TMR_CTRL_HIT_BIT = 1;

  // Decoded view of one bus access, computed combinationally each cycle.
  typedef struct packed {
    logic       io_sel;
    logic [7:0] ofs;
    logic       ram_we;
    logic       io_we;
  } access_t;

  function automatic logic is_io_page(input logic [15:0] addr);
    return addr[15:8] == IO_PAGE;
  endfunction

endpackage

// File: rtl/data_mem_timer.sv
// Free-running compare timer for the I/O page: counter, compare register,
// enable bit and sticky hit flag with write-1-to-clear.
module data_mem_timer
  import data_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_timer,
  input  logic        wr_ctrl,
  input  logic        wr_cmp,
  input  logic [15:0] wdata,
  output logic [15:0] timer_value,
  output logic [15:0] timer_cmp,
  output logic [15:0] timer_ctrl,
  output logic        hit
);

  logic enable;
  logic match;

  // Compare uses the pre-edge counter so the flag lands on the following edge.
  assign match = enable && (timer_value == timer_cmp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_value <= 16'h0000;
      timer_cmp   <= 16'h0000;
      enable      <= 1'b0;
      hit         <= 1'b0;
    end else begin
      if (wr_timer) begin
        timer_value <= wdata;
      end else if (enable) begin
        timer_value <= timer_value + 16'h0001;
      end

      if (wr_cmp) begin
        timer_cmp <= wdata;
      end

      if (wr_ctrl) begin
        enable <= wdata[TMR_CTRL_EN_BIT];
      end

      // A set and a clear on the same edge resolve to set.
      if (match) begin
        hit <= 1'b1;
      end else if (wr_ctrl && wdata[TMR_CTRL_HIT_BIT]) begin
        hit <= 1'b0;
      end
    end
  end

  always_comb begin
    timer_ctrl                   = 16'h0000;
    timer_ctrl[TMR_CTRL_EN_BIT]  = enable;
    timer_ctrl[TMR_CTRL_HIT_BIT] = hit;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: word RAM plus an I/O page at Address[15:8] == 8'hFF.
// Define DATA_MEM_TIMER_EN to build the compare timer at offsets 0x03-0x05.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2   // legal range 2..3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Address,
  input  logic [15:0] D_out,
  input  logic        mw_en,
  output logic [15:0] D_in,
  input  logic [7:0]  status,
  input  logic [15:0] io_in,
  output logic [15:0] io_out,
  output logic        timer_hit
);

  localparam int DEPTH = 1 << ADDR_W;

  // There is no handshake: every cycle is an access. Address is sampled on
  // each rising edge, D_in carries the answer until the next edge, and
  // mw_en=1 commits D_out at that same edge.
  access_t            acc;
  logic [ADDR_W-1:0]  ram_idx;
  logic [15:0]        mem [0:DEPTH-1];
  logic [15:0]        sync_q [0:SYNC_STAGES-1];
  logic [7:0]         status_q;
  logic [15:0]        io_rdata;
  logic [15:0]        rdata_next;

  always_comb begin
    acc.io_sel = is_io_page(Address);
    acc.ofs    = Address[7:0];
    // The write is qualified by reset so an access caught by reset is dropped.
    acc.ram_we = mw_en && !acc.io_sel && !reset;
    acc.io_we  = mw_en && acc.io_sel;
  end

  assign ram_idx = Address[ADDR_W-1:0];

  // RAM contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (acc.ram_we) begin
      mem[ram_idx] <= D_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_out   <= 16'h0000;
      status_q <= 8'h00;
    end else begin
      status_q <= status;
      if (acc.io_we && acc.ofs == OFS_IO_OUT) begin
        io_out <= D_out;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 16'h0000;
      end
    end else begin
      sync_q[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

`ifdef DATA_MEM_TIMER_EN
  logic [15:0] tmr_value;
  logic [15:0] tmr_cmp;
  logic [15:0] tmr_ctrl;
  logic        tmr_hit;

  data_mem_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .wr_timer    (acc.io_we && acc.ofs == OFS_TIMER),
    .wr_ctrl     (acc.io_we && acc.ofs == OFS_TMR_CTRL),
    .wr_cmp      (acc.io_we && acc.ofs == OFS_TMR_CMP),
    .wdata       (D_out),
    .timer_value (tmr_value),
    .timer_cmp   (tmr_cmp),
    .timer_ctrl  (tmr_ctrl),
    .hit         (tmr_hit)
  );

  assign timer_hit = tmr_hit;
`else
  assign timer_hit = 1'b0;
`endif

  always_comb begin
    io_rdata = 16'h0000;
    case (acc.ofs)
      OFS_IO_OUT:   io_rdata = io_out;
      OFS_IO_IN:    io_rdata = sync_q[SYNC_STAGES-1];
      OFS_STATUS:   io_rdata = {8'h00, status_q};
`ifdef DATA_MEM_TIMER_EN
      OFS_TIMER:    io_rdata = tmr_value;
      OFS_TMR_CTRL: io_rdata = tmr_ctrl;
      OFS_TMR_CMP:  io_rdata = tmr_cmp;
`endif
      default:      io_rdata = 16'h0000;
    endcase
  end

  assign rdata_next = acc.io_sel ? io_rdata : mem[ram_idx];

  // Read data is registered; the RAM read sees the pre-write word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      D_in <= 16'h0000;
    end else begin
      D_in <= rdata_next;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder, checked against a
// cycle-level reference model built from queues and plain arithmetic.
module tb_data_mem_responder;

  localparam int ADDR_W      = 8;
  localparam int SYNC_STAGES = 2;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] Address;
  logic [15:0] D_out;
  logic        mw_en;
  logic [15:0] D_in;
  logic [7:0]  status;
  logic [15:0] io_in;
  logic [15:0] io_out;
  logic        timer_hit;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .D_out     (D_out),
    .mw_en     (mw_en),
    .D_in      (D_in),
    .status    (status),
    .io_in     (io_in),
    .io_out    (io_out),
    .timer_hit (timer_hit)
  );

  // reference model state
  logic [15:0] ram_m [int];
  logic [15:0] io_hist [$];
  logic [15:0] io_out_m;
  logic [7:0]  status_m;
  logic [15:0] tmr_m, cmp_m;
  logic        en_m, hit_m;
  logic [15:0] exp_q [$];
  logic        exp_known;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    io_hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) io_hist.push_back(16'h0000);
    io_out_m = 16'h0000;
    status_m = 8'h00;
    tmr_m    = 16'h0000;
    cmp_m    = 16'h0000;
    en_m     = 1'b0;
    hit_m    = 1'b0;
  endtask

  function automatic logic [15:0] model_io_read(input logic [7:0] ofs);
    case (ofs)
      8'h00: return io_out_m;
      8'h01: return io_hist[0];
      8'h02: return {8'h00, status_m};
`ifdef DATA_MEM_TIMER_EN
      8'h03: return tmr_m;
      8'h04: return {14'b0, hit_m, en_m};
      8'h05: return cmp_m;
`endif
      default: return 16'h0000;
    endcase
  endfunction

  // Advance the model by one edge with the given access; the expected D_in
  // is pushed on exp_q (or marked unknown for never-written RAM words).
  task automatic model_step(input logic [15:0] addr, input logic [15:0] wd, input logic we);
    int   idx;
    logic io;
    logic [15:0] nxt_t;
    logic        nxt_hit;
    io  = (addr[15:8] == 8'hFF);
    idx = int'(addr) % (1 << ADDR_W);
    exp_known = 1'b1;
    if (io) exp_q.push_back(model_io_read(addr[7:0]));
    else if (ram_m.exists(idx)) exp_q.push_back(ram_m[idx]);
    else begin
      exp_known = 1'b0;
      exp_q.push_back(16'h0000);
    end
`ifdef DATA_MEM_TIMER_EN
    nxt_t   = en_m ? tmr_m + 16'd1 : tmr_m;
    nxt_hit = hit_m;
    if (we && io && addr[7:0] == 8'h04 && wd[1]) nxt_hit = 1'b0;
    if (en_m && tmr_m == cmp_m) nxt_hit = 1'b1;
    if (we && io && addr[7:0] == 8'h03) nxt_t = wd;
    if (we && io && addr[7:0] == 8'h04) en_m = wd[0];
    if (we && io && addr[7:0] == 8'h05) cmp_m = wd;
    tmr_m = nxt_t;
    hit_m = nxt_hit;
`else
    nxt_t   = 16'h0000;
    nxt_hit = 1'b0;
    tmr_m   = nxt_t;
    hit_m   = nxt_hit;
`endif
    if (we && !io) ram_m[idx] = wd;
    if (we && io && addr[7:0] == 8'h00) io_out_m = wd;
    void'(io_hist.pop_front());
    io_hist.push_back(io_in);
    status_m = status;
  endtask

  // driver: one bus cycle, then compare outputs #1 after the edge
  task automatic cyc(input logic [15:0] addr, input logic [15:0] wd, input logic we);
    logic [15:0] e;
    Address = addr;
    D_out   = wd;
    mw_en   = we;
    @(posedge clk);
    model_step(addr, wd, we);
    #1;
    e = exp_q.pop_front();
    if (exp_known) check("d_in", D_in, e);
    check("io_out", io_out, io_out_m);
    check("timer_hit", {15'b0, timer_hit}, {15'b0, hit_m});
  endtask

  initial begin
    logic seen;
    reset   = 1'b1;
    Address = 16'h0000;
    D_out   = 16'h0000;
    mw_en   = 1'b0;
    status  = 8'h00;
    io_in   = 16'h0000;
    model_reset();
    #1;
    check("rst_d_in", D_in, 16'h0000);
    check("rst_io_out", io_out, 16'h0000);
    check("rst_timer_hit", {15'b0, timer_hit}, 16'h0000);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // RAM write/read and alias
    cyc(16'h0010, 16'hBEEF, 1'b1);
    cyc(16'h0010, 16'h0000, 1'b0);
    check("ram_read", D_in, 16'hBEEF);
    cyc(16'h0110, 16'h0000, 1'b0);
    check("ram_alias", D_in, 16'hBEEF);

    // read-before-write
    cyc(16'h0020, 16'h0000, 1'b1);
    cyc(16'h0020, 16'h1234, 1'b1);
    check("rbw_old", D_in, 16'h0000);
    cyc(16'h0020, 16'h0000, 1'b0);
    check("rbw_new", D_in, 16'h1234);

    // I/O page
    cyc(16'hFF00, 16'hA5A5, 1'b1);
    check("io_out_wr", io_out, 16'hA5A5);
    io_in = 16'h00C3;
    repeat (3) cyc(16'hFF01, 16'h0000, 1'b0);
    check("io_in_sync", D_in, 16'h00C3);
    status = 8'h5A;
    repeat (2) cyc(16'hFF02, 16'h0000, 1'b0);
    check("status_rd", D_in, 16'h005A);
    cyc(16'hFF07, 16'hFFFF, 1'b1);
    cyc(16'hFF07, 16'h0000, 1'b0);
    check("unmapped_rd", D_in, 16'h0000);
    cyc(16'hFF01, 16'hFFFF, 1'b1);
    cyc(16'hFF01, 16'h0000, 1'b0);
    check("ro_ignored", D_in, 16'h00C3);

`ifdef DATA_MEM_TIMER_EN
    cyc(16'hFF05, 16'h0005, 1'b1);
    cyc(16'hFF03, 16'h0000, 1'b1);
    cyc(16'hFF04, 16'h0001, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(16'hFF03, 16'h0000, 1'b0);
      if (D_in === 16'h0005) seen = 1'b1;
    end
    check("timer_reach5", {15'b0, seen}, 16'h0001);
    check("timer_hit_set", {15'b0, timer_hit}, 16'h0001);
    cyc(16'hFF03, 16'h0005, 1'b1);
    cyc(16'hFF04, 16'h0003, 1'b1);
    check("hit_set_wins", {15'b0, timer_hit}, 16'h0001);
    cyc(16'hFF04, 16'h0002, 1'b1);
    check("hit_w1c", {15'b0, timer_hit}, 16'h0000);
    cyc(16'hFF04, 16'h0001, 1'b1);
    cyc(16'hFF03, 16'hFFFF, 1'b1);
    cyc(16'hFF03, 16'h0000, 1'b0);
    check("timer_pre_wrap", D_in, 16'hFFFF);
    cyc(16'hFF03, 16'h0000, 1'b0);
    check("timer_wrap", D_in, 16'h0000);
    cyc(16'hFF03, 16'h0100, 1'b1);
    cyc(16'hFF03, 16'h0000, 1'b0);
    check("timer_wr_wins", D_in, 16'h0100);
`else
    cyc(16'hFF03, 16'h1234, 1'b1);
    cyc(16'hFF03, 16'h0000, 1'b0);
    check("timer_off_rd", D_in, 16'h0000);
    cyc(16'hFF04, 16'h0001, 1'b1);
    cyc(16'hFF04, 16'h0000, 1'b0);
    check("ctrl_off_rd", D_in, 16'h0000);
    check("timer_off_hit", {15'b0, timer_hit}, 16'h0000);
`endif

    // async reset during an in-flight write
    cyc(16'h0030, 16'h1111, 1'b1);
    cyc(16'h0030, 16'h0000, 1'b0);
    Address = 16'h0030;
    D_out   = 16'h2222;
    mw_en   = 1'b1;
    #3 reset = 1'b1;
    #1;
    check("arst_d_in", D_in, 16'h0000);
    check("arst_io_out", io_out, 16'h0000);
    check("arst_timer_hit", {15'b0, timer_hit}, 16'h0000);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    mw_en = 1'b0;
    cyc(16'h0030, 16'h0000, 1'b0);
    check("arst_write_dropped", D_in, 16'h1111);
    cyc(16'hFF03, 16'h0000, 1'b0);
    check("arst_timer_zero", D_in, 16'h0000);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      io_in  = 16'($urandom);
      status = 8'($urandom);
      if ($urandom_range(0, 2) != 0)
        a = {8'($urandom_range(0, 254)), 4'h0, 4'($urandom_range(0, 15))};
      else
        a = {8'hFF, 8'($urandom_range(0, 7))};
      if (a[15:8] == 8'hFF && a[7:0] == 8'h05)
        cyc(a, 16'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
      else
        cyc(a, 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the processor's data/instruction bus: answers the core's `Address`/`D_out`/`mw_en` accesses with `D_in` read data. Contains a single-port word RAM plus a small memory-mapped I/O page: output port, synchronized input port, status capture, and an optional timer. Sits beside the processor top, wired point-to-point to its memory bus.

## Interface
- `ADDR_W`, 8: RAM address width; depth = 2^ADDR_W 16-bit words.
- `SYNC_STAGES`, 2: synchronizer depth for `io_in`; legal values 2..3.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Address`  in  16  word address from the core.
- `D_out`  in  16  write data from the core.
- `mw_en`  in  1  write enable; 1 = write `D_out` at `Address` this edge.
- `D_in`  out  16  registered read data to the core.
- `status`  in  8  core flag/status byte, captured for readback.
- `io_in`  in  16  asynchronous external input port.
- `io_out`  out  16  output port register.
- `timer_hit`  out  1  sticky timer compare flag. Tied 0 when the timer is compiled out.

## Operation
- Address decode:
  - `Address[15:8] != 8'hFF`: RAM. Index = `Address[ADDR_W-1:0]`; upper bits are ignored, so the RAM aliases.
  - `8'hFF`: I/O page. Offset = `Address[7:0]`.
- RAM behaviour:
  - Write when `mw_en`=1.
  - Read every cycle.
  - Read-before-write: a same-cycle read returns the old word.
  - Contents are not reset.
- I/O page:
  - 0x00 IO_OUT: R/W; drives `io_out`.
  - 0x01 IO_IN: RO; last synchronizer stage.
  - 0x02 STATUS: RO; `{8'h00, status_q}`, where `status_q` is `status` registered every cycle.
  - 0x03 TIMER: R/W; 16-bit up-counter.
  - 0x04 TMR_CTRL: bit0 = enable (R/W); bit1 = hit (write 1 to clear); other bits read 0.
  - 0x05 TMR_CMP: R/W compare value.
  - All other offsets read 16'h0000; writes to them are ignored. Writes to RO registers are ignored.
- Timer:
  - When enabled, increments by 1 per cycle and wraps 0xFFFF→0x0000.
  - When `TIMER == TMR_CMP` and enabled, sets hit on the next edge.
  - `timer_hit` = hit bit.
- Simultaneous events:
  - Core write to TIMER and increment on the same edge: the write wins (TIMER = `D_out`).
  - Compare match and W1C clear on the same edge: set wins (hit stays 1).
  - Write to TMR_CTRL: bit0 takes `D_out[0]`; bit1 is cleared only if `D_out[1]`=1.
- Reset values:
  - `D_in`=0, `io_out`=0, `timer_hit`=0.
  - TIMER=0, TMR_CMP=0, TMR_CTRL=0.
  - Synchronizer flops and `status_q` = 0.
- Reset mid-access: an in-flight write is dropped. `D_in` clears immediately, asynchronously.

## Timing
- Read latency is 1 cycle: `Address` sampled at edge N, data on `D_in` after edge N. `D_in` is registered with no combinational path from `Address`.
- Writes commit at the edge where `mw_en`=1. Readback is visible at the earliest on the `D_in` that follows edge N+1.
- `io_in` → IO_IN latency: `SYNC_STAGES` cycles.
- STATUS readback reflects `status` from 1 cycle before the read edge.
- TIMER read returns the pre-increment value at the sampling edge.
- There is no handshake or stall: every cycle is a valid access. The core must hold `Address` for one cycle per read.

## Configuration
- `DATA_MEM_TIMER_EN` defined: TIMER, TMR_CTRL and TMR_CMP are implemented, and `timer_hit` is live.
- Not defined: offsets 0x03–0x05 behave as unmapped (read 0, writes ignored), `timer_hit` is tied 0, and no timer flops are synthesized.

## Structure
- Package `data_mem_pkg`: `IO_PAGE` (8'hFF) and the offset constants `OFS_IO_OUT`, `OFS_IO_IN`, `OFS_STATUS`, `OFS_TIMER`, `OFS_TMR_CTRL`, `OFS_TMR_CMP`; TMR_CTRL bit indices.
- Sub-module `data_mem_timer`: counter, compare, ctrl and hit logic. It is instantiated only under `DATA_MEM_TIMER_EN`.
- RAM array, decode, I/O registers and the read mux live in the top module.

## Test plan
- **RAM write/read:** write 0xBEEF at 0x0010, then read 0x0010 → `D_in`=0xBEEF one cycle later. Read 0x0110 with `ADDR_W`=8 → 0xBEEF (alias).
- **Read-before-write:** read and write 0x1234 to 0x0020 on the same edge, with the location holding 0x0000 → `D_in`=0x0000. Next read → 0x1234.
- **I/O page:**
  - Write 0xA5A5 to 0xFF00 → `io_out`=0xA5A5.
  - Drive `io_in`=0x00C3 → readable at 0xFF01 after 2 cycles.
  - `status`=0x5A → 0xFF02 reads 0x005A.
  - Read 0xFF07 → 0x0000.
- **Timer (macro on):**
  - TMR_CMP=5, TMR_CTRL=1, TIMER=0 → `timer_hit` rises one cycle after TIMER reads 5.
  - Write TMR_CTRL=0x3 during a match → hit stays 1. TMR_CTRL=0x2 with no match → hit clears.
- **Wrap and priority:** TIMER=0xFFFF with enable → next value 0x0000. Write 0x0100 on an increment edge → 0x0100.
- **Async reset mid-write:** assert `reset` between edges while `mw_en`=1 → `D_in`, `io_out` and `timer_hit` go to 0 without waiting for a clock edge, and the write is not committed. With the macro off, 0xFF03 reads 0 and `timer_hit` stays 0.
